mux_scan_sampler: RTL
=====================

// Module: mux_scan_sampler
// PURPOSE
//  Sequencer upstream of the 4:1 multiplexer. Drives its 2-bit select through
//  channels 0..3, dwells DWELL clocks on each, then samples the mux output F.
//  Collects the 4 samples into a word and hands it off with a valid/ready handshake.
//  With F = D[sel], the output word equals the mux data input D.
// PARAMETERS
//  DWELL   4   clocks spent on each channel before sampling; legal range 1..255
// PORTS
//  clk         in   1  clock; all logic on posedge
//  rst_n       in   1  reset, synchronous, active-low
//  start       in   1  request one scan; sampled only in IDLE
//  sel         out  2  select to mux (mux X input)
//  mux_f       in   1  mux output F
//  word        out  4  assembled sample word; word[i] = F sampled while sel==i
//  word_valid  out  1  word available; held until accepted
//  word_ready  in   1  consumer accepts word when word_valid && word_ready
//  busy        out  1  1 in SCAN or HOLD
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE; sel=0, word=0, word_valid=0, busy=0, cnt=0.
//    Reset wins over every other input.
//    Reset mid-scan or mid-HOLD discards the partial or undelivered word.
//  - FSM states:
//    - IDLE: start -> SCAN, with sel=0, cnt=0, busy=1.
//    - SCAN: cnt increments each clock. At the edge where cnt==DWELL-1:
//        word[sel] <= mux_f; cnt <= 0.
//        If sel==3: -> HOLD, word_valid <= 1, sel <= 0.
//        Otherwise: sel <= sel+1.
//    - HOLD: word and word_valid stable until word_valid && word_ready.
//        At that edge: word_valid <= 0; -> IDLE and busy <= 0.
//        Exception: CONT_SCAN_EN defined (see CONFIGURATION).
//  - Latency: start captured at edge E0; word_valid is high after edge E0+4*DWELL.
//    Minimum start-to-start period is 4*DWELL+2 clocks when ready is held at 1.
//  - start while busy (SCAN or HOLD) is ignored. It is not queued.
//  - word_ready while word_valid==0 has no effect.
//  - sel changes only at sample edges. This gives the mux a full DWELL window to settle.
//  - DWELL==1: one sample per clock, sel advances every clock.
//  - cnt is 8 bits wide. No overflow is possible within the legal DWELL range.
//  - sel wraps 3->0 only on HOLD entry, never inside SCAN.
// CONFIGURATION
//  CONT_SCAN_EN, defined: on the handshake edge in HOLD, the FSM goes directly
//    to SCAN with sel=0, cnt=0, busy stays 1, no start needed.
//    Free-running scans continue until reset.
//  CONT_SCAN_EN, undefined: every scan requires a start pulse in IDLE.
// STRUCTURE
//  - mux_scan_defs.vh (shared include):
//    - state encodings ST_IDLE=2'd0, ST_SCAN=2'd1, ST_HOLD=2'd2
//    - NCH=4, SEL_W=2, CNT_W=8
//  - Sub-module dwell_timer:
//    - loadable 8-bit counter; inputs clk, rst_n, clr, en; output tick when cnt==DWELL-1
//    - used for the SCAN dwell
//  - The top holds the FSM, sel register and word shift/assembly.
// TESTING
//  - Bench instantiates the real 4:1 mux: D into the mux, sel to X, F to mux_f.
//  1. DWELL=4, D=4'b1010, 1-clk start, ready=1:
//     sel=0,1,2,3 for 4 clks each; word_valid=1 for 1 clk, 16 clks after start edge.
//     word=4'b1010; then IDLE, busy=0.
//  2. Backpressure, D=4'b1010, ready=0 for 10 clks after valid:
//     word/word_valid stable, busy=1.
//     Raise ready: valid drops at the next edge, busy=0.
//  3. start pulses during SCAN and HOLD: no effect on sel or timing; exactly one word delivered.
//  4. rst_n=0 for 1 clk while sel==2: all outputs 0 next edge.
//     Set D=4'b0110, start again: word=4'b0110.
//  5. DWELL=1, D=4'b0101: word_valid after 4 clks, word=4'b0101.
//     DWELL=255: valid after 1020 clks.
//  6. CONT_SCAN_EN defined, D toggles ^4'b1111 between scans, ready=1:
//     words alternate 1010/0101 with a single start pulse.
//     Without the macro, the second word requires a second start.

Source files
------------

// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and constants for the mux scan sampler.
// Optional build macro used by the top: CONT_SCAN_EN.
package mux_scan_sampler_pkg;

   localparam int unsigned NCH   = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StHold = 2'd2
   } state_e;

endpackage

// File: rtl/mux_scan_sampler_dwell_timer.sv
// Dwell counter: counts clocks spent on one channel, flags the last one.
// tick is high while cnt == DWELL-1; the count wraps to 0 on an enabled tick.
module dwell_timer
   import mux_scan_sampler_pkg::*;
#(
   parameter int unsigned DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == CNT_W'(DWELL - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr || (en && tick)) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps a 4:1 mux select through all channels, samples F after each dwell and
// delivers the 4-bit word over valid/ready. CONT_SCAN_EN: rescan without start.
module mux_scan_sampler
   import mux_scan_sampler_pkg::*;
#(
   parameter int unsigned DWELL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [SEL_W-1:0] sel,
   input  logic             mux_f,
   output logic [NCH-1:0]   word,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [NCH-1:0]   word_q, word_d;
   logic             scanning;
   logic             tick;

   assign scanning = (state_q == StScan);

   // Held clear outside SCAN so every scan starts its first dwell at 0.
   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!scanning),
      .en    (scanning),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      word_d  = word_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StScan;
               sel_d   = '0;
            end
         end
         StScan: begin
            if (tick) begin
               word_d[sel_q] = mux_f;
               if (sel_q == SEL_W'(NCH - 1)) begin
                  state_d = StHold;
                  sel_d   = '0;
               end else begin
                  sel_d = sel_q + 1'b1;
               end
            end
         end
         StHold: begin
            if (word_ready) begin
`ifdef CONT_SCAN_EN
               state_d = StScan;
`else
               state_d = StIdle;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         word_q  <= word_d;
      end
   end

   assign sel        = sel_q;
   assign word       = word_q;
   assign word_valid = (state_q == StHold);
   assign busy       = (state_q != StIdle);

endmodule
